// File: rtl/sm3_pkg.sv
// Shared constants, state encoding and word helpers for the SM3 message padder.
package sm3_pkg;

    localparam int unsigned BLK_W   = 512;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned N_WORDS = BLK_W / WORD_W;

    localparam logic [7:0]        PAD_BYTE = 8'h80;
    localparam logic [WORD_W-1:0] PAD_WORD = {PAD_BYTE, {(WORD_W-8){1'b0}}};

    localparam logic [3:0] LEN_IDX  = 4'd14;
    localparam logic [3:0] LAST_IDX = 4'd15;

    localparam logic [1:0] ST_FILL = 2'd0;
    localparam logic [1:0] ST_PADW = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;

    // Byte counts outside 1..4 on a final word mean a full word.
    function automatic logic [2:0] eff_bytes(input logic [2:0] b);
        return ((b == 3'd0) || (b > 3'd4)) ? 3'd4 : b;
    endfunction

    function automatic logic [WORD_W-1:0] pad_final_word(input logic [WORD_W-1:0] data,
                                                         input logic [2:0]        nbytes);
        logic [WORD_W-1:0] w;
        case (nbytes)
            3'd1:    w = {data[31:24], PAD_BYTE, 16'h0000};
            3'd2:    w = {data[31:16], PAD_BYTE, 8'h00};
            3'd3:    w = {data[31:8], PAD_BYTE};
            default: w = data;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sm3_msg_pad.sv
// SM3 message padder: packs 32-bit big-endian words into 512-bit blocks and
// appends the 0x80 marker, zero fill and 64-bit bit-length.
module sm3_msg_pad
    import sm3_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_valid,
    input  logic               in_last,
    input  logic [2:0]         in_bytes,
    output logic               in_ready,
    output logic [BLK_W-1:0]   blk_data,
    output logic               blk_valid,
    output logic               blk_last,
    input  logic               blk_ready
);

    logic [1:0]        state_q, state_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic [63:0]       len_q, len_d;
    logic              pad_q, pad_d;
    logic              pend80_q, pend80_d;
    logic              lenhi_q, lenhi_d;
    logic              blk_last_q, blk_last_d;
    logic [WORD_W-1:0] buf_q [N_WORDS];
    logic [WORD_W-1:0] buf_d [N_WORDS];

    logic              wr_en;
    logic [WORD_W-1:0] wr_word;
    logic [2:0]        eb;

    assign in_ready  = (state_q == ST_FILL);
    assign blk_valid = (state_q == ST_EMIT);
    assign blk_last  = blk_last_q;

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        len_d      = len_q;
        pad_d      = pad_q;
        pend80_d   = pend80_q;
        lenhi_d    = lenhi_q;
        blk_last_d = blk_last_q;
        wr_en      = 1'b0;
        wr_word    = '0;
        eb         = eff_bytes(in_bytes);

        case (state_q)
            ST_FILL: begin
                if (in_valid) begin
                    wr_en  = 1'b1;
                    wcnt_d = wcnt_q + 4'd1;
                    if (in_last) begin
                        wr_word    = pad_final_word(in_data, eb);
                        len_d      = len_q + {58'd0, eb, 3'd0};
                        pad_d      = 1'b1;
                        pend80_d   = (eb == 3'd4);
                        blk_last_d = 1'b0;
                        state_d    = (wcnt_q == LAST_IDX) ? ST_EMIT : ST_PADW;
                    end else begin
                        wr_word = in_data;
                        len_d   = len_q + 64'd32;
                        state_d = (wcnt_q == LAST_IDX) ? ST_EMIT : ST_FILL;
                    end
                end
            end

            ST_PADW: begin
                wr_en  = 1'b1;
                wcnt_d = wcnt_q + 4'd1;
                // Length goes in only when 0x80 already sits below index 14;
                // otherwise this block is zero-filled and the length moves on.
                if (pend80_q) begin
                    wr_word  = PAD_WORD;
                    pend80_d = 1'b0;
                end else if (wcnt_q == LEN_IDX) begin
                    wr_word = len_q[63:32];
                    lenhi_d = 1'b1;
                end else if ((wcnt_q == LAST_IDX) && lenhi_q) begin
                    wr_word    = len_q[31:0];
                    blk_last_d = 1'b1;
                end else begin
                    wr_word = '0;
                end
                if (wcnt_q == LAST_IDX) begin
                    state_d = ST_EMIT;
                end
            end

            ST_EMIT: begin
                if (blk_ready) begin
                    wcnt_d = '0;
                    if (blk_last_q) begin
                        state_d    = ST_FILL;
                        len_d      = '0;
                        pad_d      = 1'b0;
                        pend80_d   = 1'b0;
                        lenhi_d    = 1'b0;
                        blk_last_d = 1'b0;
                    end else if (pad_q) begin
                        state_d = ST_PADW;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end

            default: begin
                state_d = ST_FILL;
                wcnt_d  = '0;
            end
        endcase
    end

    always_comb begin
        buf_d = buf_q;
        if (wr_en) begin
            buf_d[wcnt_q] = wr_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FILL;
            wcnt_q     <= '0;
            len_q      <= '0;
            pad_q      <= 1'b0;
            pend80_q   <= 1'b0;
            lenhi_q    <= 1'b0;
            blk_last_q <= 1'b0;
            for (int unsigned i = 0; i < N_WORDS; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            len_q      <= len_d;
            pad_q      <= pad_d;
            pend80_q   <= pend80_d;
            lenhi_q    <= lenhi_d;
            blk_last_q <= blk_last_d;
            buf_q      <= buf_d;
        end
    end

    for (genvar g = 0; g < N_WORDS; g++) begin : g_out
        assign blk_data[BLK_W-1-WORD_W*g -: WORD_W] = buf_q[g];
    end

endmodule
